ram_tx_streamer: RTL and testbench
==================================

RAM_TX_STREAMER -- requirements
Module: ram_tx_streamer

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 63516, number of bytes streamed per dump (addresses 0..NUM_BYTES-1).
REQ-002 SHALL have parameter SB_TICK, default 16, number of s_tick periods in the stop bit.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 SHALL have port s_tick  input  1  one-cycle pulse at 16x baud from the baud rate generator.
REQ-007 SHALL have port ram_addr  output  16  RAM read address.
REQ-008 SHALL have port ram_dout  input  8  RAM read data; valid 1 clk after ram_addr changes (synchronous read).
REQ-009 SHALL have port tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-010 SHALL have port busy  output  1  high from start acceptance until done.
REQ-011 SHALL have port tx_done_tick  output  1  one-cycle pulse at end of each byte's stop bit.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last byte's stop bit.

Function
REQ-013 SHALL implement states IDLE, FETCH, LOAD, START, DATA, STOP, NEXT.
REQ-014 IDLE: tx=1, busy=0; on start=1 -> FETCH, ram_addr=0, busy=1 next cycle.
REQ-015 FETCH: hold ram_addr one cycle -> LOAD (RAM latency).
REQ-016 LOAD: latch ram_dout into shift register, clear tick counter -> START.
REQ-017 START: tx=0; count s_tick; on 16th s_tick -> DATA, bit counter=0, tick counter=0.
REQ-018 DATA: tx=shift[0]; on 16th s_tick shift right; after bit 7 -> STOP.
REQ-019 STOP: tx=1; on SB_TICK-th s_tick pulse tx_done_tick -> NEXT.
REQ-020 NEXT: if ram_addr==NUM_BYTES-1, pulse done, ram_addr=0, busy=0 -> IDLE; else ram_addr+1 -> FETCH.
REQ-021 s_tick SHALL be counted only in START, DATA, STOP; ticks in other states ignored.
REQ-022 start SHALL be ignored while busy=1; no restart, no address change.
REQ-023 ram_addr SHALL not wrap past NUM_BYTES-1; done SHALL be asserted exactly once per dump.
REQ-024 Inter-byte gap SHALL be exactly 3 clk (NEXT, FETCH, LOAD) plus alignment to next s_tick.
REQ-025 NUM_BYTES=1 SHALL send one frame then done, with no FETCH for address 1.
REQ-026 tx SHALL be registered (glitch-free); tx_done_tick and done SHALL be registered pulses.
REQ-027 Tick counter 4 bits, bit counter 3 bits; no overflow beyond stated terminal counts.

Reset
REQ-028 reset=1 SHALL immediately force state=IDLE, tx=1, busy=0, done=0, tx_done_tick=0, ram_addr=0, counters=0, shift register=0.
REQ-029 Reset mid-frame SHALL abort the dump; no done pulse; next start restarts from address 0.
REQ-030 After reset deassertion the block SHALL remain in IDLE until a start pulse.

Verification
REQ-031 NUM_BYTES=4, RAM={0x55,0xA3,0x00,0xFF}, s_tick every 4 clk, start pulse -> four 8N1 frames decode to 0x55,0xA3,0x00,0xFF; 4 tx_done_tick; one done; ram_addr=0 after.
REQ-032 Frame timing: byte 0x01 -> tx low exactly 16 s_ticks (start), bit0 high 16 s_ticks, bits1-7 low 112 s_ticks, stop high 16 s_ticks.
REQ-033 start pulsed again during byte 2 of a 4-byte dump -> ignored; still exactly 4 frames and one done.
REQ-034 reset asserted mid-DATA of byte 1 -> tx=1 and busy=0 same cycle, no done; new start resends from address 0.
REQ-035 NUM_BYTES=1, RAM[0]=0xC3 -> single frame 0xC3, tx_done_tick and done, ram_addr never exceeds 0.
REQ-036 s_tick held high continuously with start -> frame completes in 16+128+16 tick-clocks; no tick counted in FETCH/LOAD/NEXT.

Source files
------------

// File: rtl/ram_tx_streamer_if.sv
// Bundle between the dump controller, its RAM, the baud tick source
// and the UART line.
interface ram_tx_streamer_if;
    logic        start;
    logic        s_tick;
    logic [15:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        tx;
    logic        busy;
    logic        tx_done_tick;
    logic        done;

    modport master (
        output start, s_tick, ram_dout,
        input  ram_addr, tx, busy, tx_done_tick, done
    );

    modport slave (
        input  start, s_tick, ram_dout,
        output ram_addr, tx, busy, tx_done_tick, done
    );
endinterface

// File: rtl/ram_tx_streamer.sv
// Streams RAM addresses 0..NUM_BYTES-1 out of an 8N1 UART transmitter,
// one frame per byte, with a done pulse after the last stop bit.
module ram_tx_streamer #(
    parameter int NUM_BYTES = 63516,
    parameter int SB_TICK   = 16
) (
    input logic               clk,
    input logic               reset,
    ram_tx_streamer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, STOP, NEXT
    } state_t;

    localparam logic [15:0] LAST_ADDR = 16'(NUM_BYTES - 1);
    localparam logic [3:0]  SB_LAST   = 4'(SB_TICK - 1);

    state_t      r_state, w_state;
    logic [3:0]  r_tick, w_tick;
    logic [2:0]  r_bit, w_bit;
    logic [7:0]  r_shift, w_shift;
    logic [15:0] r_addr, w_addr;
    logic        r_tx, w_tx;
    logic        r_busy, w_busy;
    logic        r_txd, w_txd;
    logic        r_done, w_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_addr  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_txd   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_tick  <= w_tick;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_addr  <= w_addr;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
            r_txd   <= w_txd;
            r_done  <= w_done;
        end
    end

    always_comb begin
        w_state = r_state;
        w_tick  = r_tick;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_addr  = r_addr;
        w_busy  = r_busy;
        w_txd   = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state = FETCH;
                    w_addr  = '0;
                    w_busy  = 1'b1;
                end
            end
            FETCH: w_state = LOAD;
            LOAD: begin
                w_shift = bus.ram_dout;
                w_tick  = '0;
                w_state = START;
            end
            START: begin
                if (bus.s_tick) begin
                    if (r_tick == 4'd15) begin
                        w_state = DATA;
                        w_tick  = '0;
                        w_bit   = '0;
                    end else begin
                        w_tick = r_tick + 4'd1;
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (r_tick == 4'd15) begin
                        w_tick  = '0;
                        w_shift = {1'b0, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            w_state = STOP;
                        end else begin
                            w_bit = r_bit + 3'd1;
                        end
                    end else begin
                        w_tick = r_tick + 4'd1;
                    end
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    if (r_tick == SB_LAST) begin
                        w_txd   = 1'b1;
                        w_tick  = '0;
                        w_state = NEXT;
                    end else begin
                        w_tick = r_tick + 4'd1;
                    end
                end
            end
            NEXT: begin
                if (r_addr == LAST_ADDR) begin
                    w_done  = 1'b1;
                    w_addr  = '0;
                    w_busy  = 1'b0;
                    w_state = IDLE;
                end else begin
                    w_addr  = r_addr + 16'd1;
                    w_state = FETCH;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // Line level follows the next state so tx changes on the same edge
    // as the state that owns it.
    always_comb begin
        w_tx = 1'b1;
        case (w_state)
            START:   w_tx = 1'b0;
            DATA:    w_tx = w_shift[0];
            default: w_tx = 1'b1;
        endcase
    end

    assign bus.ram_addr     = r_addr;
    assign bus.tx           = r_tx;
    assign bus.busy         = r_busy;
    assign bus.tx_done_tick = r_txd;
    assign bus.done         = r_done;
endmodule

// File: tb/tb_ram_tx_streamer.sv
// Bench for ram_tx_streamer: 4-byte and 1-byte dumps decoded by a
// tick-sampling 8N1 receiver.
module tb_ram_tx_streamer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic st4 = 1'b0;
    logic st1 = 1'b0;
    logic sel1 = 1'b0;
    int   period = 4;
    int   tcnt = 0;

    always #5 clk = ~clk;

    ram_tx_streamer_if bus4();
    ram_tx_streamer_if bus1();

    ram_tx_streamer #(.NUM_BYTES(4), .SB_TICK(16)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4.slave)
    );
    ram_tx_streamer #(.NUM_BYTES(1), .SB_TICK(16)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    assign bus4.start  = st4;
    assign bus1.start  = st1;
    assign bus4.s_tick = tick;
    assign bus1.s_tick = tick;

    logic [7:0] mem4 [4];
    logic [7:0] mem1 = 8'h00;

    always @(posedge clk) begin
        bus4.ram_dout <= mem4[bus4.ram_addr[1:0]];
        bus1.ram_dout <= mem1;
    end

    always @(posedge clk) begin
        #1;
        if (period <= 1) begin
            tick = 1'b1;
        end else begin
            tcnt = (tcnt + 1) % period;
            tick = (tcnt == 0);
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Receiver: one sample of the line per s_tick, 160 samples per frame
    logic       line;
    assign line = sel1 ? bus1.tx : bus4.tx;
    int         rx_idx = -1;
    int         gap = 0;
    int         slot, pos;
    logic       rx_ref;
    logic       rx_ok;
    logic [7:0] rx_sh;
    logic [7:0] rxq [$];
    bit         okq [$];
    int         gapq [$];

    int done4 = 0, txd4 = 0, done1 = 0, txd1 = 0;
    int max4 = 0, max1 = 0;

    always @(negedge clk) begin
        if (reset) begin
            rx_idx = -1;
            gap = 0;
        end else begin
            if (bus4.done) done4++;
            if (bus4.tx_done_tick) txd4++;
            if (bus1.done) done1++;
            if (bus1.tx_done_tick) txd1++;
            if (int'(bus4.ram_addr) > max4) max4 = int'(bus4.ram_addr);
            if (int'(bus1.ram_addr) > max1) max1 = int'(bus1.ram_addr);
            if (tick) begin
                if (rx_idx < 0) begin
                    if (line === 1'b0) begin
                        rx_idx = 1;
                        rx_ref = 1'b0;
                        rx_ok = 1'b1;
                        rx_sh = 8'h00;
                    end else begin
                        gap++;
                    end
                end else begin
                    slot = rx_idx / 16;
                    pos = rx_idx % 16;
                    if (pos == 0) rx_ref = line;
                    else if (line !== rx_ref) rx_ok = 1'b0;
                    if (slot >= 1 && slot <= 8 && pos == 0)
                        rx_sh[slot-1] = line;
                    if (slot == 9 && line !== 1'b1) rx_ok = 1'b0;
                    rx_idx++;
                    if (rx_idx == 160) begin
                        rxq.push_back(rx_sh);
                        okq.push_back(rx_ok);
                        gapq.push_back(gap);
                        gap = 0;
                        rx_idx = -1;
                    end
                end
            end
        end
    end

    typedef struct {
        logic [3:0][7:0] d;
        int              per;
        bit              restart;
        logic [3:0][7:0] e;
    } vec_t;

    vec_t tbl [3];

    task automatic clear_obs();
        rxq.delete();
        okq.delete();
        gapq.delete();
        done4 = 0; txd4 = 0; done1 = 0; txd1 = 0;
        max4 = 0; max1 = 0;
    endtask

    task automatic pulse4();
        @(posedge clk); #1 st4 = 1'b1;
        @(posedge clk); #1 st4 = 1'b0;
    endtask

    task automatic wait_done4();
        int n;
        n = 0;
        while (done4 == 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        repeat (200) @(posedge clk);
        #2;
    endtask

    task automatic check_dump4(input vec_t v, input string tag);
        chk({tag, "_done_count"}, done4, 1);
        chk({tag, "_tx_done_count"}, txd4, 4);
        chk({tag, "_frames"}, rxq.size(), 4);
        for (int i = 0; i < 4 && i < rxq.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), rxq[i], v.e[i]);
            chk($sformatf("%s_timing%0d", tag, i), okq[i], 1);
            if (v.per == 1 && i > 0)
                chk($sformatf("%s_gap%0d", tag, i), gapq[i], 3);
        end
        chk({tag, "_addr_end"}, bus4.ram_addr, 0);
        chk({tag, "_busy_end"}, bus4.busy, 0);
        chk({tag, "_tx_end"}, bus4.tx, 1);
        chk({tag, "_addr_max"}, (max4 <= 3), 1);
    endtask

    initial begin
        tbl[0].d = {8'hFF, 8'h00, 8'hA3, 8'h55};
        tbl[0].per = 4; tbl[0].restart = 1'b0;
        tbl[0].e = {8'hFF, 8'h00, 8'hA3, 8'h55};
        tbl[1].d = {8'hC3, 8'h7E, 8'h80, 8'h01};
        tbl[1].per = 1; tbl[1].restart = 1'b1;
        tbl[1].e = {8'hC3, 8'h7E, 8'h80, 8'h01};
        tbl[2].d = {8'h5A, 8'hF0, 8'h0F, 8'hAA};
        tbl[2].per = 3; tbl[2].restart = 1'b1;
        tbl[2].e = {8'h5A, 8'hF0, 8'h0F, 8'hAA};
        for (int i = 0; i < 4; i++) mem4[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_tx", bus4.tx, 1);
        chk("rst_busy", bus4.busy, 0);
        chk("rst_addr", bus4.ram_addr, 0);
        chk("rst_done", bus4.done, 0);
        chk("rst_txd", bus4.tx_done_tick, 0);
        reset = 1'b0;
        clear_obs();
        repeat (60) @(negedge clk);
        chk("idle_busy", bus4.busy, 0);
        chk("idle_tx", bus4.tx, 1);
        chk("idle_frames", rxq.size(), 0);
        chk("idle_busy1", bus1.busy, 0);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) mem4[i] = tbl[k].d[i];
            period = tbl[k].per;
            clear_obs();
            pulse4();
            chk($sformatf("v%0d_busy_start", k), bus4.busy, 1);
            chk($sformatf("v%0d_addr_start", k), bus4.ram_addr, 0);
            if (tbl[k].restart) begin
                for (int n = 0; n < 20000; n++) begin
                    if (rxq.size() == 2 && rx_idx >= 40) break;
                    @(posedge clk);
                end
                pulse4();
                chk($sformatf("v%0d_restart_addr", k), bus4.ram_addr, 2);
                chk($sformatf("v%0d_restart_busy", k), bus4.busy, 1);
            end
            wait_done4();
            check_dump4(tbl[k], $sformatf("v%0d", k));
        end

        // Reset during the data bits of byte 1
        mem4[0] = 8'h11; mem4[1] = 8'h22;
        mem4[2] = 8'h33; mem4[3] = 8'h44;
        period = 2;
        clear_obs();
        pulse4();
        for (int n = 0; n < 20000; n++) begin
            if (bus4.ram_addr == 16'd1 && rx_idx >= 40) break;
            @(posedge clk);
        end
        @(negedge clk); #2 reset = 1'b1;
        #1;
        chk("midrst_tx", bus4.tx, 1);
        chk("midrst_busy", bus4.busy, 0);
        chk("midrst_addr", bus4.ram_addr, 0);
        @(posedge clk); @(negedge clk); #1 reset = 1'b0;
        clear_obs();
        repeat (100) @(posedge clk);
        #2;
        chk("midrst_no_done", done4, 0);
        chk("midrst_idle", bus4.busy, 0);
        tbl[0].d = {8'h44, 8'h33, 8'h22, 8'h11};
        tbl[0].e = {8'h44, 8'h33, 8'h22, 8'h11};
        tbl[0].per = 2;
        clear_obs();
        pulse4();
        wait_done4();
        check_dump4(tbl[0], "resend");

        // Single-byte dump on the NUM_BYTES=1 instance
        sel1 = 1'b1;
        mem1 = 8'hC3;
        period = 4;
        clear_obs();
        @(posedge clk); #1 st1 = 1'b1;
        @(posedge clk); #1 st1 = 1'b0;
        chk("one_busy_start", bus1.busy, 1);
        for (int n = 0; n < 20000; n++) begin
            if (done1 != 0) break;
            @(posedge clk);
        end
        repeat (200) @(posedge clk);
        #2;
        chk("one_done", done1, 1);
        chk("one_txd", txd1, 1);
        chk("one_frames", rxq.size(), 1);
        if (rxq.size() > 0) begin
            chk("one_byte", rxq[0], 8'hC3);
            chk("one_timing", okq[0], 1);
        end
        chk("one_addr_max", max1, 0);
        chk("one_busy_end", bus1.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
